// File: rtl/glyph_seq_pkg.sv
// rtl/glyph_seq_pkg.sv - shared constants, control bit map, FSM states and default palette
package glyph_seq_pkg;

    localparam logic [3:0] PAL_ADDR_MAX = 4'd7;
    localparam logic [3:0] CTRL_ADDR    = 4'd8;
    localparam logic [3:0] STEP_ADDR    = 4'd9;

    localparam int CTRL_W           = 4;
    localparam int CTRL_PAUSE_BIT   = 0;
    localparam int CTRL_SPEED_LSB   = 1;
    localparam int CTRL_SPEED_MSB   = 2;
    localparam int CTRL_REVERSE_BIT = 3;

    typedef enum logic [1:0] {
        RUN,
        COMMIT,
        ADVANCE
    } seq_state_e;

    // Entry 0 sits in the low six bits; the first element listed is entry 7.
    localparam logic [7:0][5:0] DEFAULT_PALETTE = {
        6'b101110, 6'b011110, 6'b011101, 6'b001101,
        6'b001100, 6'b001000, 6'b000100, 6'b000000
    };

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - delayed copy of vsync and a pulse on entry into the active level
module sync_edge_det #(
    parameter logic VSYNC_POL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic sig_i,
    output logic start_o
);

    logic sig_d_q;

    // Previous-cycle copy; resets to the inactive level so reset never fakes an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sig_d_q <= ~VSYNC_POL;
        end else begin
            sig_d_q <= sig_i;
        end
    end

    assign start_o = (sig_i == VSYNC_POL) && (sig_d_q != VSYNC_POL);

endmodule

// File: rtl/glyph_frame_sequencer.sv
// rtl/glyph_frame_sequencer.sv - shadowed palette/animation control committed at vsync start; GLYPH_SEQ_STEP_EN enables single-step
module glyph_frame_sequencer
    import glyph_seq_pkg::*;
#(
    parameter int   CNT_W     = 10,
    parameter logic VSYNC_POL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             vsync_in,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [3:0]       cfg_addr,
    input  logic [5:0]       cfg_data,
    output logic [47:0]      palette_flat,
    output logic [CNT_W-1:0] frame_cnt,
    output logic             frame_tick,
    output logic             paused
);

    seq_state_e        state_q;
    logic              cfg_ready_q;
    logic              frame_tick_q;
    logic [CNT_W-1:0]  frame_cnt_q;
    logic [7:0][5:0]   shadow_pal_q;
    logic [7:0][5:0]   commit_pal_q;
    logic [CTRL_W-1:0] shadow_ctrl_q;
    logic [CTRL_W-1:0] commit_ctrl_q;

    logic              start_edge;
    logic              cfg_fire;
    logic              step_go;
    logic [CNT_W-1:0]  step_amt;

    sync_edge_det #(
        .VSYNC_POL (VSYNC_POL)
    ) u_edge (
        .clk     (clk),
        .reset   (reset),
        .sig_i   (vsync_in),
        .start_o (start_edge)
    );

    // cfg_ready is high exactly while in RUN, so a handshake can only land in RUN.
    assign cfg_fire = cfg_valid && cfg_ready_q;
    assign step_amt = {{(CNT_W-1){1'b0}}, 1'b1} << commit_ctrl_q[CTRL_SPEED_MSB:CTRL_SPEED_LSB];

    // Shadow registers collect writes during the frame; addresses 10-15 fall through untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_pal_q  <= DEFAULT_PALETTE;
            shadow_ctrl_q <= '0;
        end else if (cfg_fire) begin
            if (cfg_addr <= PAL_ADDR_MAX) begin
                shadow_pal_q[cfg_addr[2:0]] <= cfg_data;
            end else if (cfg_addr == CTRL_ADDR) begin
                shadow_ctrl_q <= cfg_data[CTRL_W-1:0];
            end
        end
    end

`ifdef GLYPH_SEQ_STEP_EN
    logic step_pending_q;

    // Step request survives until the next ADVANCE consumes it, whether or not it moves the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_pending_q <= 1'b0;
        end else if (cfg_fire && (cfg_addr == STEP_ADDR)) begin
            step_pending_q <= 1'b1;
        end else if (state_q == ADVANCE) begin
            step_pending_q <= 1'b0;
        end
    end

    assign step_go = step_pending_q;
`else
    assign step_go = 1'b0;
`endif

    // Frame FSM: RUN waits for the start edge, COMMIT copies shadows, ADVANCE moves the counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= RUN;
            cfg_ready_q   <= 1'b1;
            frame_tick_q  <= 1'b0;
            frame_cnt_q   <= '0;
            commit_pal_q  <= DEFAULT_PALETTE;
            commit_ctrl_q <= '0;
        end else begin
            frame_tick_q <= 1'b0;
            case (state_q)
                RUN: begin
                    if (start_edge) begin
                        state_q     <= COMMIT;
                        cfg_ready_q <= 1'b0;
                    end
                end
                COMMIT: begin
                    commit_pal_q  <= shadow_pal_q;
                    commit_ctrl_q <= shadow_ctrl_q;
                    frame_tick_q  <= 1'b1;
                    state_q       <= ADVANCE;
                end
                ADVANCE: begin
                    if (!commit_ctrl_q[CTRL_PAUSE_BIT] || step_go) begin
                        if (commit_ctrl_q[CTRL_REVERSE_BIT]) begin
                            frame_cnt_q <= frame_cnt_q - step_amt;
                        end else begin
                            frame_cnt_q <= frame_cnt_q + step_amt;
                        end
                    end
                    state_q     <= RUN;
                    cfg_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= RUN;
                    cfg_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign cfg_ready    = cfg_ready_q;
    assign frame_tick   = frame_tick_q;
    assign frame_cnt    = frame_cnt_q;
    assign palette_flat = commit_pal_q;
    assign paused       = commit_ctrl_q[CTRL_PAUSE_BIT];

endmodule

// File: doc/glyph_frame_sequencer.md
Name: glyph_frame_sequencer

Overview:
Frame-level controller for the glyph-mode VGA datapath. Replaces the vsync-clocked animation counter with a fully synchronous one on the pixel clock. Holds the 8-entry RRGGBB palette and the animation controls (pause/speed/reverse) in shadow registers, written over a valid/ready config port. Commits them atomically at the start of each vsync pulse, so colour changes never tear mid-frame.

Parameters:
CNT_W, 10, width of animation frame counter (datapath uses counter[CNT_W-1:3])
VSYNC_POL, 1'b0, active level of vsync_in; 0 = active-low pulse (640x480 default)

Ports:
clk  input  1  pixel clock, same clock as hvsync_generator
reset  input  1  asynchronous, active-high reset
vsync_in  input  1  raw vsync from hvsync_generator
cfg_valid  input  1  config write request
cfg_ready  output  1  config write accepted when valid & ready
cfg_addr  input  4  0-7 palette entry, 8 control, 9 step
cfg_data  input  6  write data (RRGGBB for palette; control bits below)
palette_flat  output  48  committed palette, entry i at [6i+5:6i]
frame_cnt  output  CNT_W  committed animation counter
frame_tick  output  1  one-cycle pulse when frame_cnt updates
paused  output  1  committed pause bit

Behaviour:
- Control reg (addr 8): bit0 pause; bits[2:1] speed, step = 1<<speed (1,2,4,8); bit3 reverse; bits[5:4] ignored.
- Reset values:
  - frame_cnt=0, frame_tick=0, paused=0, cfg_ready=1, state=RUN.
  - Shadow and committed palette = {000000,000100,001000,001100,001101,011101,011110,101110} (entries 0..7).
  - Shadow/committed control = 0; vsync_d = inactive level.
- Edge detect: vsync_d registers vsync_in. Start edge = (vsync_in==VSYNC_POL) & (vsync_d!=VSYNC_POL).
- FSM states:
  - RUN: cfg_ready=1. On start edge -> COMMIT.
  - COMMIT (1 cycle): cfg_ready=0; shadow palette/control copied to committed regs -> ADVANCE.
  - ADVANCE (1 cycle): cfg_ready=0; frame_tick=1. If committed pause=0, frame_cnt += step (reverse=0) or -= step (reverse=1). Arithmetic is mod 2^CNT_W (wraps both ways). If paused, frame_cnt holds unless a step is pending. Returns to RUN.
- Latency: vsync_in edge at cycle N -> committed outputs change at N+2, frame_tick high in cycle N+2, frame_cnt updated at N+3.
- Config writes:
  - Accepted only in RUN, and take effect at the next commit.
  - A write in the same cycle as the start edge is accepted and lands in that commit.
  - Addr 10-15 are accepted and discarded.
  - Multiple writes to one addr per frame: the last write wins.
- Step (addr 9, any data): sets step_pending. In ADVANCE with committed pause=1 and step_pending, frame_cnt moves by one step and step_pending clears. With pause=0 it clears without extra motion.
- vsync_in glitch shorter than 3 cycles: only one commit per start edge; a new edge during COMMIT/ADVANCE is ignored.
- Reset asserted mid-frame or mid-COMMIT: all state returns to reset values immediately; pending shadow writes are lost.

Optional Feature:
GLYPH_SEQ_STEP_EN
- Defined: addr 9 single-step behaves as above.
- Undefined: step_pending logic is not built; addr 9 writes are accepted and discarded; a paused counter only moves after unpause.

Decomposition:
- Package glyph_seq_pkg:
  - Address constants PAL_ADDR_MAX=7, CTRL_ADDR=8, STEP_ADDR=9.
  - Control bit indices.
  - FSM enum {RUN, COMMIT, ADVANCE}.
  - Default palette constant array.
- Sub-module sync_edge_det: vsync_d register plus start-edge pulse, parameterised on VSYNC_POL.
- Everything else lives in one module.

Test Plan:
- Reset, then 3 active-low vsync pulses with no writes -> frame_tick pulses 3 times, frame_cnt 0->1->2->3, palette_flat[47:42]=101110.
- Write addr 8 data 6'b000100 (speed=2, step 4) mid-frame -> frame_cnt unchanged until next pulse; then steps 0->4->8.
- Write addr 3=6'b110000 in the same cycle as the vsync start edge -> accepted; palette_flat[23:18]=110000 at edge+2. A second write at edge+1 sees cfg_ready=0.
- Control 6'b001000 (reverse) from frame_cnt=0 -> 1023 after one frame (wrap); speed=3 -> 1015.
- Pause (addr 8=1), then write addr 9 -> exactly one step of 1 on the next frame, then held for 2 further frames. With GLYPH_SEQ_STEP_EN undefined -> held throughout.
- Reset asserted at COMMIT cycle with shadow addr 0=111111 -> palette_flat[5:0]=000000 after reset, frame_cnt=0, cfg_ready=1.
